// File: rtl/uart_stream_bridge.sv
// -----------------------------------------------------------------------------
// uart_stream_bridge
//
// Bus initiator for the UART core's parallel CPU-side interface. Bytes offered
// on the TX valid/ready stream become single-cycle UART write strobes. Bytes
// held by the UART are drained through single-cycle read strobes into a 1-deep
// RX valid/ready buffer, tagged with the parity/framing error flags. When both
// directions want the bus at once, they take turns.
//
// Parameters
//   RX_SETTLE  cycles (1..7) spent in SETTLE after a read strobe
//   TX_SETTLE  cycles (1..7) spent in SETTLE after a write strobe
//   CNT_W      width of the saturating error counters
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   TX_DATA/VALID/READY   inbound byte stream to transmit
//   RX_DATA/PERR/FERR     received byte with its error tags
//   RX_VALID/READY        outbound handshake for the received byte
//   UART_CSN/WEN/OEN      registered active-low UART strobes
//   UART_DATA_IN          registered byte driven to the UART
//   UART_DATA_OUT         byte presented by the UART
//   UART_TXRDY/RXRDY      UART can accept a byte / holds a byte
//   UART_*_ERR, OVERFLOW  UART status flags
//   PERR/FERR/OVF_COUNT   saturating error counters
//   BUSY                  a transaction or settle period is in progress
// -----------------------------------------------------------------------------
module uart_stream_bridge #(
    parameter int RX_SETTLE = 2,
    parameter int TX_SETTLE = 2,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [7:0]       RX_DATA,
    output logic             RX_PERR,
    output logic             RX_FERR,
    output logic             RX_VALID,
    input  logic             RX_READY,
    output logic             UART_CSN,
    output logic             UART_WEN,
    output logic             UART_OEN,
    output logic [7:0]       UART_DATA_IN,
    input  logic [7:0]       UART_DATA_OUT,
    input  logic             UART_TXRDY,
    input  logic             UART_RXRDY,
    input  logic             UART_PARITY_ERR,
    input  logic             UART_FRAMING_ERR,
    input  logic             UART_OVERFLOW,
    output logic [CNT_W-1:0] PERR_COUNT,
    output logic [CNT_W-1:0] FERR_COUNT,
    output logic [CNT_W-1:0] OVF_COUNT,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        WR     = 2'd2,
        SETTLE = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_TX = 1'b0,
        GRANT_RX = 1'b1
    } grant_t;

    localparam logic [2:0]       RX_SETTLE_CNT = 3'(RX_SETTLE);
    localparam logic [2:0]       TX_SETTLE_CNT = 3'(TX_SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;
    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     state_next;
    logic [2:0] settle_cnt;
    logic [2:0] settle_cnt_next;
    grant_t     last_grant;

    logic rx_elig;
    logic tx_fire;
    logic rx_fire;
    logic ovf_prev;

    logic csn_next;
    logic wen_next;
    logic oen_next;

    // ------------------------------------------------------------------------
    // Arbitration. TX_READY is withheld only when RX would win a tie, so a
    // producer sees a stable ready independent of its own TX_VALID.
    // ------------------------------------------------------------------------
    assign rx_elig  = UART_RXRDY & ~RX_VALID;
    assign TX_READY = ~RESET & (state == IDLE) & UART_TXRDY
                    & ~(rx_elig & (last_grant == GRANT_TX));
    assign tx_fire  = TX_VALID & TX_READY;
    // RX takes the bus whenever it is eligible and TX did not win this cycle.
    assign rx_fire  = (state == IDLE) & rx_elig & ~tx_fire;
    assign BUSY     = (state != IDLE);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next      = state;
        settle_cnt_next = settle_cnt;
        case (state)
            IDLE: begin
                if (tx_fire) begin
                    state_next = WR;
                end else if (rx_fire) begin
                    state_next = RD;
                end
            end
            RD: begin
                state_next      = SETTLE;
                settle_cnt_next = RX_SETTLE_CNT;
            end
            WR: begin
                state_next      = SETTLE;
                settle_cnt_next = TX_SETTLE_CNT;
            end
            SETTLE: begin
                // The count loaded on entry equals the number of SETTLE cycles.
                settle_cnt_next = settle_cnt - 3'd1;
                if (settle_cnt <= 3'd1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: strobe levels for the coming cycle, registered below so
    // the UART sees glitch-free strobes that are low exactly while in RD/WR.
    // ------------------------------------------------------------------------
    always_comb begin
        csn_next = ~((state_next == RD) | (state_next == WR));
        wen_next = (state_next != WR);
        oen_next = (state_next != RD);
    end

    // ------------------------------------------------------------------------
    // State register, UART output registers, RX buffer and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RESET) begin
            state        <= IDLE;
            settle_cnt   <= 3'd0;
            last_grant   <= GRANT_TX;
            UART_CSN     <= 1'b1;
            UART_WEN     <= 1'b1;
            UART_OEN     <= 1'b1;
            UART_DATA_IN <= 8'h00;
            RX_DATA      <= 8'h00;
            RX_PERR      <= 1'b0;
            RX_FERR      <= 1'b0;
            RX_VALID     <= 1'b0;
            ovf_prev     <= 1'b0;
            PERR_COUNT   <= '0;
            FERR_COUNT   <= '0;
            OVF_COUNT    <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
            UART_CSN   <= csn_next;
            UART_WEN   <= wen_next;
            UART_OEN   <= oen_next;

            if (tx_fire) begin
                UART_DATA_IN <= TX_DATA;
                last_grant   <= GRANT_TX;
            end
            if (rx_fire) begin
                last_grant <= GRANT_RX;
            end

            // RD is only entered with an empty buffer, so capture and drain
            // never coincide.
            if (state == RD) begin
                RX_DATA  <= UART_DATA_OUT;
                RX_PERR  <= UART_PARITY_ERR;
                RX_FERR  <= UART_FRAMING_ERR;
                RX_VALID <= 1'b1;
                if (UART_PARITY_ERR && (PERR_COUNT != CNT_MAX)) begin
                    PERR_COUNT <= PERR_COUNT + CNT_ONE;
                end
                if (UART_FRAMING_ERR && (FERR_COUNT != CNT_MAX)) begin
                    FERR_COUNT <= FERR_COUNT + CNT_ONE;
                end
            end else if (RX_VALID && RX_READY) begin
                RX_DATA  <= 8'h00;
                RX_PERR  <= 1'b0;
                RX_FERR  <= 1'b0;
                RX_VALID <= 1'b0;
            end

            ovf_prev <= UART_OVERFLOW;
            if (UART_OVERFLOW && !ovf_prev && (OVF_COUNT != CNT_MAX)) begin
                OVF_COUNT <= OVF_COUNT + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_stream_bridge
//
// Directed bench for uart_stream_bridge. Expected UART strobe events and
// expected RX stream bytes are pushed into queues as stimulus is issued; two
// monitor processes pop and compare them whenever the DUT strobes the UART or
// hands off an RX byte. Timing, counter and reset expectations are checked
// directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_uart_stream_bridge;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [7:0]       TX_DATA;
    logic             TX_VALID;
    logic             TX_READY;
    logic [7:0]       RX_DATA;
    logic             RX_PERR;
    logic             RX_FERR;
    logic             RX_VALID;
    logic             RX_READY;
    logic             UART_CSN;
    logic             UART_WEN;
    logic             UART_OEN;
    logic [7:0]       UART_DATA_IN;
    logic [7:0]       UART_DATA_OUT;
    logic             UART_TXRDY;
    logic             UART_RXRDY;
    logic             UART_PARITY_ERR;
    logic             UART_FRAMING_ERR;
    logic             UART_OVERFLOW;
    logic [CNT_W-1:0] PERR_COUNT;
    logic [CNT_W-1:0] FERR_COUNT;
    logic [CNT_W-1:0] OVF_COUNT;
    logic             BUSY;

    always #5 CLK = ~CLK;

    uart_stream_bridge #(
        .RX_SETTLE(2),
        .TX_SETTLE(2),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .TX_DATA         (TX_DATA),
        .TX_VALID        (TX_VALID),
        .TX_READY        (TX_READY),
        .RX_DATA         (RX_DATA),
        .RX_PERR         (RX_PERR),
        .RX_FERR         (RX_FERR),
        .RX_VALID        (RX_VALID),
        .RX_READY        (RX_READY),
        .UART_CSN        (UART_CSN),
        .UART_WEN        (UART_WEN),
        .UART_OEN        (UART_OEN),
        .UART_DATA_IN    (UART_DATA_IN),
        .UART_DATA_OUT   (UART_DATA_OUT),
        .UART_TXRDY      (UART_TXRDY),
        .UART_RXRDY      (UART_RXRDY),
        .UART_PARITY_ERR (UART_PARITY_ERR),
        .UART_FRAMING_ERR(UART_FRAMING_ERR),
        .UART_OVERFLOW   (UART_OVERFLOW),
        .PERR_COUNT      (PERR_COUNT),
        .FERR_COUNT      (FERR_COUNT),
        .OVF_COUNT       (OVF_COUNT),
        .BUSY            (BUSY)
    );

    typedef enum logic {EV_RD = 1'b0, EV_WR = 1'b1} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] data;
    } bus_ev_t;

    bus_ev_t    bus_q[$];
    logic [9:0] rx_q[$];      // {data, perr, ferr}
    int         total = 0;
    int         bad   = 0;
    int         rd_pulses = 0;

    bus_ev_t    bus_exp;
    ev_kind_t   bus_obs;
    logic [9:0] rx_exp;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor: every cycle with a strobe low must match the next expected
    // UART transaction, so a stretched or extra strobe shows up as a surplus.
    always @(negedge CLK) begin
        if (!UART_CSN || !UART_WEN || !UART_OEN) begin
            check("strobe_cs_low", UART_CSN, 1'b0);
            check("strobe_exclusive", UART_WEN ^ UART_OEN, 1'b1);
            bus_obs = UART_WEN ? EV_RD : EV_WR;
            if (bus_obs == EV_RD) rd_pulses++;
            check("bus_event_expected", (bus_q.size() > 0), 1'b1);
            if (bus_q.size() > 0) begin
                bus_exp = bus_q.pop_front();
                check("bus_kind", bus_obs, bus_exp.kind);
                if (bus_exp.kind == EV_WR) begin
                    check("bus_wr_data", UART_DATA_IN, bus_exp.data);
                end
            end
        end
    end

    // RX stream monitor: compare on each accepted byte.
    always @(negedge CLK) begin
        if (RX_VALID && RX_READY) begin
            check("rx_byte_expected", (rx_q.size() > 0), 1'b1);
            if (rx_q.size() > 0) begin
                rx_exp = rx_q.pop_front();
                check("rx_byte", {RX_DATA, RX_PERR, RX_FERR}, rx_exp);
            end
        end
    end

    task automatic wait_tx_ready(input string name);
        int n = 0;
        @(negedge CLK);
        while (!TX_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check(name, TX_READY, 1'b1);
    endtask

    task automatic wait_rx_valid(input string name);
        int n = 0;
        @(negedge CLK);
        while (!RX_VALID && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check(name, RX_VALID, 1'b1);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd_before;

        RESET            = 1'b1;
        TX_DATA          = 8'h00;
        TX_VALID         = 1'b0;
        RX_READY         = 1'b0;
        UART_DATA_OUT    = 8'h00;
        UART_TXRDY       = 1'b1;
        UART_RXRDY       = 1'b0;
        UART_PARITY_ERR  = 1'b0;
        UART_FRAMING_ERR = 1'b0;
        UART_OVERFLOW    = 1'b0;
        repeat (3) @(posedge CLK);

        // ---- reset state --------------------------------------------------
        @(negedge CLK);
        check("rst_strobes", {UART_CSN, UART_WEN, UART_OEN}, 3'b111);
        check("rst_data_in", UART_DATA_IN, 8'h00);
        check("rst_rx", {RX_DATA, RX_PERR, RX_FERR, RX_VALID}, 11'h000);
        check("rst_busy", BUSY, 1'b0);
        check("rst_tx_ready", TX_READY, 1'b0);
        check("rst_counts", {PERR_COUNT, FERR_COUNT, OVF_COUNT}, 12'h000);

        // ---- single write of 0xA5 -----------------------------------------
        step();
        RESET    = 1'b0;
        TX_DATA  = 8'hA5;
        TX_VALID = 1'b1;
        bus_q.push_back('{EV_WR, 8'hA5});
        @(negedge CLK);
        check("wr_tx_ready", TX_READY, 1'b1);
        step();                       // handshake edge, now in WR
        TX_VALID = 1'b0;
        @(negedge CLK);
        check("wr_strobe", {UART_CSN, UART_WEN, UART_OEN}, 3'b001);
        check("wr_data_in", UART_DATA_IN, 8'hA5);
        check("wr_busy", BUSY, 1'b1);
        @(negedge CLK);
        check("wr_settle1_strobes", {UART_CSN, UART_WEN}, 2'b11);
        check("wr_settle1_ready", TX_READY, 1'b0);
        @(negedge CLK);
        check("wr_settle2_ready", TX_READY, 1'b0);
        @(negedge CLK);
        check("wr_idle_ready", TX_READY, 1'b1);
        check("wr_idle_busy", BUSY, 1'b0);

        // ---- read of 0x3C held by backpressure ----------------------------
        step();
        UART_TXRDY    = 1'b0;
        UART_RXRDY    = 1'b1;
        UART_DATA_OUT = 8'h3C;
        RX_READY      = 1'b0;
        rd_before     = rd_pulses;
        bus_q.push_back('{EV_RD, 8'h00});
        rx_q.push_back({8'h3C, 1'b0, 1'b0});
        repeat (12) @(negedge CLK);
        check("rd_valid_held", RX_VALID, 1'b1);
        check("rd_data", RX_DATA, 8'h3C);
        check("rd_single_pulse", rd_pulses - rd_before, 1);
        step();
        RX_READY   = 1'b1;
        UART_RXRDY = 1'b0;
        step();
        RX_READY = 1'b0;
        @(negedge CLK);
        check("rd_drained", RX_VALID, 1'b0);

        // ---- alternating arbitration after a fresh reset ------------------
        step();
        RESET         = 1'b1;
        UART_TXRDY    = 1'b1;
        UART_RXRDY    = 1'b1;
        UART_DATA_OUT = 8'h81;
        RX_READY      = 1'b1;
        TX_VALID      = 1'b1;
        TX_DATA       = 8'h11;
        bus_q.push_back('{EV_RD, 8'h00});
        bus_q.push_back('{EV_WR, 8'h11});
        bus_q.push_back('{EV_RD, 8'h00});
        bus_q.push_back('{EV_WR, 8'h22});
        rx_q.push_back({8'h81, 1'b0, 1'b0});
        rx_q.push_back({8'h81, 1'b0, 1'b0});
        step();
        RESET = 1'b0;
        wait_tx_ready("alt_wr1_ready");
        step();
        TX_DATA = 8'h22;
        wait_tx_ready("alt_wr2_ready");
        step();
        TX_VALID   = 1'b0;
        UART_RXRDY = 1'b0;
        repeat (8) @(negedge CLK);
        check("alt_bus_drained", bus_q.size(), 0);
        check("alt_rx_drained", rx_q.size(), 0);

        // ---- capture with both error tags ---------------------------------
        step();
        RX_READY         = 1'b0;
        UART_TXRDY       = 1'b0;
        UART_RXRDY       = 1'b1;
        UART_DATA_OUT    = 8'h5A;
        UART_PARITY_ERR  = 1'b1;
        UART_FRAMING_ERR = 1'b1;
        bus_q.push_back('{EV_RD, 8'h00});
        rx_q.push_back({8'h5A, 1'b1, 1'b1});
        wait_rx_valid("err_rx_valid");
        step();
        UART_RXRDY       = 1'b0;
        UART_PARITY_ERR  = 1'b0;
        UART_FRAMING_ERR = 1'b0;
        @(negedge CLK);
        check("err_tags", {RX_PERR, RX_FERR}, 2'b11);
        check("err_perr_count", PERR_COUNT, 1);
        check("err_ferr_count", FERR_COUNT, 1);
        step();
        RX_READY = 1'b1;
        step();
        RX_READY = 1'b0;

        // ---- overflow edge counting and saturation ------------------------
        UART_OVERFLOW = 1'b1;
        repeat (10) step();
        UART_OVERFLOW = 1'b0;
        @(negedge CLK);
        check("ovf_level_once", OVF_COUNT, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            UART_OVERFLOW = 1'b1;
            step();
            UART_OVERFLOW = 1'b0;
            if (i == 13) begin
                @(negedge CLK);
                check("ovf_reach_max", OVF_COUNT, 15);
            end
        end
        @(negedge CLK);
        check("ovf_saturated", OVF_COUNT, 15);

        // ---- reset during WR with a buffered RX byte ----------------------
        step();
        UART_RXRDY    = 1'b1;
        UART_DATA_OUT = 8'h77;
        bus_q.push_back('{EV_RD, 8'h00});
        wait_rx_valid("rstwr_rx_buffered");
        step();
        UART_RXRDY = 1'b0;
        UART_TXRDY = 1'b1;
        TX_DATA    = 8'hC3;
        TX_VALID   = 1'b1;
        bus_q.push_back('{EV_WR, 8'hC3});
        wait_tx_ready("rstwr_tx_ready");
        step();                       // now in WR
        TX_VALID = 1'b0;
        RESET    = 1'b1;
        @(negedge CLK);
        check("rstwr_in_wr", UART_WEN, 1'b0);
        @(negedge CLK);
        check("rstwr_strobes", {UART_CSN, UART_WEN, UART_OEN}, 3'b111);
        check("rstwr_data_in", UART_DATA_IN, 8'h00);
        check("rstwr_rx_valid", RX_VALID, 1'b0);
        check("rstwr_busy", BUSY, 1'b0);
        check("rstwr_tx_ready", TX_READY, 1'b0);
        check("rstwr_counts", {PERR_COUNT, FERR_COUNT, OVF_COUNT}, 12'h000);
        step();
        RESET      = 1'b0;
        UART_TXRDY = 1'b0;
        repeat (5) @(negedge CLK);
        check("end_bus_drained", bus_q.size(), 0);
        check("end_rx_drained", rx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
